// File: rtl/prog_bitstream_loader.sv
// rtl/prog_bitstream_loader.sv - serializes config bytes LSB-first onto the tinyFPGA prog chain
// and assembles the bits returned on the chain's data-out into readback bytes.
module prog_bitstream_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int CLK_DIV   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       prog_clk,
   output logic       prog_rst,
   output logic       prog_en,
   output logic       prog_data,
   input  logic       prog_data_ret,
   output logic [7:0] readback_byte,
   output logic       readback_valid,
   output logic       busy,
   output logic       done
);

   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int DW = $clog2(2 * CLK_DIV) + 1;
   localparam logic [DW-1:0] RST_LAST = DW'(2 * CLK_DIV - 1);
   localparam logic [DW-1:0] PH_LAST  = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {IDLE, CHAIN_RST, WAIT_BYTE, SHIFT, FINISH} state_t;

   state_t          state, state_nxt;
   logic [DW-1:0]   div_cnt;
   logic            phase;
   logic [2:0]      bit_idx;
   logic [CW-1:0]   bit_cnt;
   logic [7:0]      shreg;
   logic [7:0]      rb_shift;
   logic            ph_end;
   logic            byte_end;

   assign ph_end   = (div_cnt == PH_LAST);
   // A byte closes after 8 bits, or early on the chain's last bit.
   assign byte_end = (bit_idx == 3'd7) || (bit_cnt == BIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b1;
      data_ready = 1'b0;
      prog_clk   = 1'b0;
      prog_rst   = 1'b0;
      prog_en    = 1'b0;
      prog_data  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = CHAIN_RST;
         end
         CHAIN_RST: begin
            prog_rst = 1'b1;
            if (div_cnt == RST_LAST) state_nxt = WAIT_BYTE;
         end
         WAIT_BYTE: begin
            data_ready = 1'b1;
            prog_en    = 1'b1;
            if (data_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            prog_en   = 1'b1;
            prog_clk  = phase;
            prog_data = shreg[0];
            if (phase && ph_end && byte_end)
               state_nxt = (bit_cnt == BIT_LAST) ? FINISH : WAIT_BYTE;
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt        <= '0;
         phase          <= 1'b0;
         bit_idx        <= 3'd0;
         bit_cnt        <= '0;
         shreg          <= 8'd0;
         rb_shift       <= 8'd0;
         readback_byte  <= 8'd0;
         readback_valid <= 1'b0;
         done           <= 1'b0;
      end else begin
         readback_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  done    <= 1'b0;
                  bit_cnt <= '0;
                  div_cnt <= '0;
               end
            end
            CHAIN_RST: begin
               div_cnt <= (div_cnt == RST_LAST) ? '0 : div_cnt + DW'(1);
            end
            WAIT_BYTE: begin
               if (data_valid) begin
                  shreg    <= data_in;
                  bit_idx  <= 3'd0;
                  div_cnt  <= '0;
                  phase    <= 1'b0;
                  rb_shift <= 8'd0;
               end
            end
            SHIFT: begin
               if (!ph_end) begin
                  div_cnt <= div_cnt + DW'(1);
               end else if (!phase) begin
                  // Returned bit is taken just before the chain's rising edge.
                  rb_shift <= {prog_data_ret, rb_shift[7:1]};
                  phase    <= 1'b1;
                  div_cnt  <= '0;
               end else begin
                  phase   <= 1'b0;
                  div_cnt <= '0;
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_cnt + CW'(1);
                  bit_idx <= bit_idx + 3'd1;
                  if (byte_end) begin
                     readback_valid <= 1'b1;
                     readback_byte  <= rb_shift >> (3'd7 - bit_idx);
                  end
               end
            end
            FINISH:  done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_bitstream_loader.sv
// tb/tb_prog_bitstream_loader.sv - self-checking bench for prog_bitstream_loader
// Two instances: 16-bit chain / div 2 and 10-bit chain / div 1, each with a loopback chain model.
module tb_prog_bitstream_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s [2];
   logic       valid_s [2];
   logic       ready_s [2];
   logic       pclk_s  [2];
   logic       prst_s  [2];
   logic       pen_s   [2];
   logic       pdata_s [2];
   logic       ret_s   [2];
   logic       rbv_s   [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic [7:0] din_s   [2];
   logic [7:0] rbb_s   [2];

   logic [15:0] chain  [2] = '{16'h0000, 16'h0000};
   logic        pclk_q [2] = '{1'b0, 1'b0};

   int         n_cmp = 0;
   int         n_fail = 0;
   int         sel = 0;
   logic       bit_q[$];
   logic [7:0] rb_q[$];
   int         rst_cnt = 0;
   int         hi_run = 0;
   bit         hi_bad = 1'b0;
   logic       mon_prev = 1'b0;

   typedef struct {
      int         dut;
      logic [7:0] b0;
      logic [7:0] b1;
      int         stall;
      bit         mid;
      bit         chk;
      logic [15:0] rb;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   prog_bitstream_loader #(.CHAIN_LEN(16), .CLK_DIV(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_s[0]), .data_in(din_s[0]), .data_valid(valid_s[0]),
      .data_ready(ready_s[0]), .prog_clk(pclk_s[0]), .prog_rst(prst_s[0]), .prog_en(pen_s[0]),
      .prog_data(pdata_s[0]), .prog_data_ret(ret_s[0]), .readback_byte(rbb_s[0]),
      .readback_valid(rbv_s[0]), .busy(busy_s[0]), .done(done_s[0]));

   prog_bitstream_loader #(.CHAIN_LEN(10), .CLK_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_s[1]), .data_in(din_s[1]), .data_valid(valid_s[1]),
      .data_ready(ready_s[1]), .prog_clk(pclk_s[1]), .prog_rst(prst_s[1]), .prog_en(pen_s[1]),
      .prog_data(pdata_s[1]), .prog_data_ret(ret_s[1]), .readback_byte(rbb_s[1]),
      .readback_valid(rbv_s[1]), .busy(busy_s[1]), .done(done_s[1]));

   // External chain: a plain shift register clocked by prog_clk rising edges.
   assign ret_s[0] = chain[0][15];
   assign ret_s[1] = chain[1][9];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (pclk_s[d] && !pclk_q[d]) chain[d] <= {chain[d][14:0], pdata_s[d]};
         pclk_q[d] <= pclk_s[d];
      end
   end

   function automatic int cdiv(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   function automatic int clen(input int d);
      return (d == 0) ? 16 : 10;
   endfunction

   always @(negedge clk) begin
      if (pclk_s[sel] && !mon_prev) bit_q.push_back(pdata_s[sel]);
      if (pclk_s[sel]) hi_run++;
      else begin
         if (mon_prev && hi_run != cdiv(sel)) hi_bad = 1'b1;
         hi_run = 0;
      end
      if (prst_s[sel]) rst_cnt++;
      if (rbv_s[sel]) rb_q.push_back(rbb_s[sel]);
      mon_prev = pclk_s[sel];
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic run_load(input int d, input logic [7:0] b0, input logic [7:0] b1,
                           input int stall, input bit mid, input bit chk_rb, input logic [15:0] rb_exp);
      int          cl, cd, nb, cyc, i, stall_left, lat_exp, idx;
      logic [7:0]  bytes [2];
      logic [15:0] snap, exp_bits, got_bits, exp_rb, got_rb;
      logic        acc, stall_bad;
      cl = clen(d); cd = cdiv(d); nb = (cl + 7) / 8;
      bytes[0] = b0; bytes[1] = b1;
      snap = chain[d];
      sel = d;
      bit_q.delete(); rb_q.delete();
      rst_cnt = 0; hi_bad = 1'b0; stall_bad = 1'b0;
      lat_exp = 2*cd + cl*2*cd + nb + 2 + stall;
      @(negedge clk);
      start_s[d] = 1'b1;
      cyc = 0; i = 0; acc = 1'b0; stall_left = stall;
      while (cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start_s[d] = 1'b0;
         if (acc) i++;
         acc = 1'b0;
         if (cyc == 1) chk("done_cleared_busy_set", {done_s[d], busy_s[d]}, 2'b01);
         if (mid && cyc == ((d == 0) ? 30 : 10)) start_s[d] = 1'b1;
         if (done_s[d]) break;
         if (i == 1 && stall_left > 0 && ready_s[d]) begin
            if (pclk_s[d] !== 1'b0 || pen_s[d] !== 1'b1) stall_bad = 1'b1;
            valid_s[d] = 1'b0;
            stall_left--;
         end else begin
            valid_s[d] = (i < nb);
         end
         din_s[d] = bytes[(i < nb) ? i : 0];
         acc = valid_s[d] & ready_s[d];
      end
      valid_s[d] = 1'b0;
      chk("latency", cyc, lat_exp);
      chk("done_idle", {done_s[d], busy_s[d]}, 2'b10);
      chk("prog_rst_cycles", rst_cnt, 2*cd);
      chk("prog_clk_pulses", bit_q.size(), cl);
      chk("prog_clk_high_width", hi_bad, 0);
      if (stall > 0) chk("stall_hold", stall_bad, 0);
      exp_bits = '0; got_bits = '0;
      for (int k = 0; k < cl; k++) begin
         exp_bits[k] = bytes[k / 8][k % 8];
         if (k < bit_q.size()) got_bits[k] = bit_q[k];
      end
      chk("prog_data_bits", got_bits, exp_bits);
      exp_rb = '0;
      for (int j = 0; j < nb; j++)
         for (int b = 0; b < 8; b++) begin
            idx = 8*j + b;
            if (idx < cl) exp_rb[idx] = snap[cl - 1 - idx];
         end
      chk("readback_count", rb_q.size(), nb);
      got_rb = (rb_q.size() == 2) ? {rb_q[1], rb_q[0]} : 16'hxxxx;
      chk("readback_model", got_rb, exp_rb);
      if (chk_rb) chk("readback_const", got_rb, rb_exp);
      chk("readback_hold", rbb_s[d], (rb_q.size() == 2) ? rb_q[1] : 8'hxx);
   endtask

   initial begin
      int n;
      tbl[0] = '{0, 8'hA5, 8'h3C, 0,  1'b0, 1'b1, 16'h0000};
      tbl[1] = '{0, 8'hA5, 8'h3C, 0,  1'b0, 1'b1, 16'h3CA5};
      tbl[2] = '{1, 8'hFF, 8'hFE, 0,  1'b0, 1'b1, 16'h0000};
      tbl[3] = '{1, 8'h5A, 8'h03, 0,  1'b0, 1'b1, 16'h02FF};
      tbl[4] = '{0, 8'h11, 8'h22, 20, 1'b0, 1'b1, 16'h3CA5};
      tbl[5] = '{0, 8'h77, 8'h88, 0,  1'b1, 1'b1, 16'h2211};
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0; valid_s[d] = 1'b0; din_s[d] = 8'h00;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++)
         chk("reset_outputs", {busy_s[d], done_s[d], ready_s[d], pclk_s[d], prst_s[d], pen_s[d],
                               pdata_s[d], rbv_s[d], rbb_s[d]}, 0);
      rst = 1'b0;

      foreach (tbl[v])
         run_load(tbl[v].dut, tbl[v].b0, tbl[v].b1, tbl[v].stall, tbl[v].mid, tbl[v].chk, tbl[v].rb);

      sel = 0;
      bit_q.delete();
      @(negedge clk);
      start_s[0] = 1'b1;
      valid_s[0] = 1'b1; din_s[0] = 8'hC3;
      @(negedge clk);
      start_s[0] = 1'b0;
      n = 0;
      while (bit_q.size() < 5 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("reset_test_reached_5_bits", (bit_q.size() >= 5), 1);
      rst = 1'b1;
      #1;
      chk("midshift_reset_outputs", {busy_s[0], done_s[0], ready_s[0], pclk_s[0], prst_s[0], pen_s[0],
                                     pdata_s[0], rbv_s[0], rbb_s[0]}, 0);
      valid_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("midshift_reset_no_done", done_s[0], 0);
      rst = 1'b0;

      for (int r = 0; r < 8; r++)
         run_load($urandom_range(0, 1), 8'($urandom), 8'($urandom), $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), 1'b0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_bitstream_loader.md
Name: prog_bitstream_loader

Overview:
Upstream feeder for the tinyFPGA programming port. Accepts configuration bytes over a valid/ready interface and serializes them LSB-first onto the prog shift chain, generating the prog clock, enable and reset. Captures the bits returned on the chain's data-out into readback bytes so the host can verify them. Sits between the host/SPI byte source and the tinyFPGA prog pins.

Parameters:
CHAIN_LEN, 64, total configuration bits in the chain (>=1, need not be a multiple of 8)
CLK_DIV, 2, clk cycles per prog_clk half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a load sequence when idle
data_in  in  8  config byte; bit0 shifted first
data_valid  in  1  data_in valid
data_ready  out  1  loader accepts data_in this cycle
prog_clk  out  1  to chain progClk
prog_rst  out  1  to chain progRst (active-high)
prog_en  out  1  to chain progEn
prog_data  out  1  to chain progDataIn
prog_data_ret  in  1  from chain progDataOut
readback_byte  out  8  assembled returned bits, LSB = first returned
readback_valid  out  1  one-cycle pulse; readback_byte valid
busy  out  1  sequence in progress
done  out  1  high from completion until next accepted start

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; counters cleared. Reset mid-shift abandons the load, no partial done.
- States: IDLE, CHAIN_RST, WAIT_BYTE, SHIFT, FINISH.
- IDLE: busy=0. start=1 -> CHAIN_RST, done<=0, bit counter<=0. start ignored in any other state.
- CHAIN_RST: prog_rst=1 for exactly 2*CLK_DIV cycles, prog_en=0, prog_clk=0; then -> WAIT_BYTE.
- WAIT_BYTE: data_ready=1 (only state where it is 1), prog_clk=0, prog_en=1. data_valid&data_ready -> latch data_in into shift register, -> SHIFT next cycle. Source may stall indefinitely; prog_clk stays low.
- SHIFT, per bit: low phase CLK_DIV cycles (prog_clk=0, prog_data=shreg[0]); high phase CLK_DIV cycles (prog_clk=1, prog_data held). prog_data stable across whole bit period; chain samples on prog_clk rising edge.
- Readback: prog_data_ret sampled on the last clk cycle of each low phase, shifted into readback register MSB-in (so first returned bit ends in bit0 after 8 bits).
- At end of each high phase: shreg>>1, bit counter+1. After 8 bits of a byte, or when counter==CHAIN_LEN: pulse readback_valid for one cycle with readback_byte. Partial final byte: only CHAIN_LEN mod 8 bits shifted, unused upper bits of data_in ignored, readback_byte right-aligned with upper bits 0.
- After a byte: counter<CHAIN_LEN -> WAIT_BYTE; counter==CHAIN_LEN -> FINISH.
- FINISH: one cycle, prog_en<=0, prog_clk=0, -> IDLE with done=1, busy=0.
- busy=1 in every state except IDLE. prog_en=1 from entry to WAIT_BYTE through SHIFT.
- Bytes consumed = ceil(CHAIN_LEN/8). Minimum total latency start->done (no stalls): 2*CLK_DIV + CHAIN_LEN*2*CLK_DIV + ceil(CHAIN_LEN/8)*1 + 2 cycles.
- readback_byte holds its value between pulses; cleared only by rst.

Test Plan:
- Reset mid-SHIFT (CHAIN_LEN=16, CLK_DIV=2): assert rst after 5 bits -> all outputs 0 same cycle, done stays 0, next start runs full sequence.
- Basic load (CHAIN_LEN=16, CLK_DIV=2): start, bytes 0xA5, 0x3C with zero stall -> prog_data sequence at rising edges 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; 16 prog_clk pulses each 2 high/2 low cycles; prog_rst high 4 cycles first; done rises at cycle 4+64+2+2.
- Loopback readback: tie prog_data_ret to prog_data delayed by 16 bits (model 16-bit chain), load 0xA5,0x3C then repeat -> second pass readback pulses 0xA5 then 0x3C.
- Partial byte (CHAIN_LEN=10, CLK_DIV=1): bytes 0xFF, 0xFE -> exactly 10 prog_clk pulses, second byte shifts bits 0,1 only (0,1), 2 readback pulses, second readback upper 6 bits 0.
- Stall/backpressure: hold data_valid low 20 cycles in WAIT_BYTE -> prog_clk stays 0, prog_en stays 1, data_ready stays 1; no bit lost after resume.
- Start while busy: pulse start mid-SHIFT -> ignored; bit count and done timing unchanged; start after done clears done and restarts.
